// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: memory access codes, FSM states,
// latched request layout and alignment classification helpers.
package lsu_pkg;

   localparam logic       MEM_READ  = 1'b0;
   localparam logic       MEM_WRITE = 1'b1;

   localparam logic [1:0] MEM_BYTE  = 2'b00;
   localparam logic [1:0] MEM_HALF  = 2'b01;
   localparam logic [1:0] MEM_WORD  = 2'b10;
   localparam logic [1:0] MEM_ILL   = 2'b11;

   typedef enum logic [1:0] {
      LSU_IDLE  = 2'd0,
      LSU_BEAT0 = 2'd1,
      LSU_BEAT1 = 2'd2,
      LSU_DONE  = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic        rw;
      logic [1:0]  size;
      logic        sign;
      logic [1:0]  off;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == MEM_HALF && off[0]) || (size == MEM_WORD && off != 2'b00);
   endfunction

   // Accesses whose last byte lands in the next word.
   function automatic logic is_crossing(input logic [1:0] size, input logic [1:0] off);
      return (size == MEM_HALF && off == 2'b11) || (size == MEM_WORD && off != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for one bus beat: byte strobes, lane-aligned store data and
// the extracted, extended load value from up to two raw bus words.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        memrw,
   input  logic [1:0]  memword,
   input  logic        memsign,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic        beat,
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext
);

   logic [3:0]  size_mask;
   logic [7:0]  strb8;
   logic [63:0] wsh;
   logic [31:0] rsh;

   always_comb begin
      size_mask = 4'b0000;
      case (memword)
         MEM_BYTE: size_mask = 4'b0001;
         MEM_HALF: size_mask = 4'b0011;
         MEM_WORD: size_mask = 4'b1111;
         default:  size_mask = 4'b0000;
      endcase
   end

   // Two-word view: the low word is beat 0, the high word spills into beat 1.
   assign strb8    = {4'b0000, size_mask} << off;
   assign wsh      = {32'b0, wdata} << {off, 3'b000};
   assign rsh      = 32'({word1, word0} >> {off, 3'b000});

   assign wstrb    = (memrw == MEM_READ) ? 4'hF : (beat ? strb8[7:4] : strb8[3:0]);
   assign wdata_sh = beat ? wsh[63:32] : wsh[31:0];

   always_comb begin
      rdata_ext = rsh;
      case (memword)
         MEM_BYTE: rdata_ext = {{24{~memsign & rsh[7]}}, rsh[7:0]};
         MEM_HALF: rdata_ext = {{16{~memsign & rsh[15]}}, rsh[15:0]};
         default:  rdata_ext = rsh;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store responder: runs each access as one or two word beats on a
// valid/ready bus and stalls the core until it retires. LSU_MISALIGN_SPLIT_EN
// enables misaligned accesses (split into two beats when they cross a word).
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BUS_TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              memrw,
   input  logic [1:0]        memword,
   input  logic              memsign,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              stall,
   output logic              err,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_wstrb,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata
);

   localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

   lsu_state_e        state, state_n;
   lsu_req_t          req;
   logic [ADDR_W-1:2] word_addr;
   logic [TW-1:0]     tcnt;
   logic              err_q, err_n;
   logic [31:0]       rdata_q, rdata_n;
   logic              in_beat, beat1, timeout, reject, crossing;
   logic [31:0]       word0, ext;

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [31:0] beat_buf;

   assign reject   = (memword == MEM_ILL);
   assign crossing = is_crossing(req.size, req.off);
   assign word0    = crossing ? beat_buf : bus_rdata;

   always_ff @(posedge clk) begin
      if (rst)
         beat_buf <= '0;
      else if (state == LSU_BEAT0 && bus_ready && crossing)
         beat_buf <= bus_rdata;
   end
`else
   assign reject   = (memword == MEM_ILL) || is_misaligned(memword, addr[1:0]);
   assign crossing = 1'b0;
   assign word0    = bus_rdata;
`endif

   assign in_beat = (state == LSU_BEAT0) || (state == LSU_BEAT1);
   assign beat1   = (state == LSU_BEAT1);
   assign timeout = (BUS_TIMEOUT != 0) && !bus_ready && (tcnt == TW'(BUS_TIMEOUT - 1));

   lsu_align u_align (
      .memrw     (req.rw),
      .memword   (req.size),
      .memsign   (req.sign),
      .off       (req.off),
      .wdata     (req.wdata),
      .beat      (beat1),
      .word0     (word0),
      .word1     (bus_rdata),
      .wstrb     (bus_wstrb),
      .wdata_sh  (bus_wdata),
      .rdata_ext (ext)
   );

   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      rdata_n = rdata_q;
      case (state)
         LSU_IDLE: begin
            if (req_valid) begin
               if (reject) begin
                  state_n = LSU_DONE;
                  err_n   = 1'b1;
                  rdata_n = '0;
               end else begin
                  state_n = LSU_BEAT0;
               end
            end
         end
         LSU_BEAT0, LSU_BEAT1: begin
            if (bus_ready) begin
               if (state == LSU_BEAT0 && crossing) begin
                  state_n = LSU_BEAT1;
               end else begin
                  state_n = LSU_DONE;
                  rdata_n = (req.rw == MEM_READ) ? ext : '0;
               end
            end else if (timeout) begin
               state_n = LSU_DONE;
               err_n   = 1'b1;
               rdata_n = '0;
            end
         end
         LSU_DONE: state_n = LSU_IDLE;
         default:  state_n = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LSU_IDLE;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         req       <= '0;
         word_addr <= '0;
         tcnt      <= '0;
      end else begin
         state   <= state_n;
         err_q   <= err_n;
         rdata_q <= rdata_n;
         if (state == LSU_IDLE && req_valid) begin
            req       <= '{rw: memrw, size: memword, sign: memsign, off: addr[1:0], wdata: wdata};
            word_addr <= addr[ADDR_W-1:2];
         end
         // Counts consecutive unanswered cycles of the current beat.
         if (in_beat && !bus_ready)
            tcnt <= tcnt + 1'b1;
         else
            tcnt <= '0;
      end
   end

   assign done      = (state == LSU_DONE);
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign stall     = in_beat || (state == LSU_IDLE && req_valid);
   assign bus_valid = in_beat;
   assign bus_we    = (req.rw == MEM_WRITE);
   assign bus_addr  = {word_addr + (ADDR_W-2)'(beat1), 2'b00};

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a byte-level memory model and a randomized bus responder
// checked against directed scenarios and a random access stream.
module tb_lsu;

   logic        clk, rst, req_valid, memrw, memsign;
   logic [1:0]  memword;
   logic [31:0] addr, wdata, rdata;
   logic        done, stall, err;
   logic        bus_valid, bus_ready, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   int checks = 0;
   int errors = 0;

   lsu #(.ADDR_W(32), .BUS_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .memrw(memrw), .memword(memword),
      .memsign(memsign), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
      .stall(stall), .err(err), .bus_valid(bus_valid), .bus_ready(bus_ready),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // bmem is what the bus saw; rmem is what the byte-level model expects.
   logic [31:0] bmem [logic [31:0]];
   logic [31:0] rmem [logic [31:0]];

   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'hA5C3_0F69 ^ {a[15:0], a[31:16]};
   endfunction
   function automatic logic [31:0] bmem_rd(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : pat(a);
   endfunction
   function automatic logic [31:0] rmem_rd(input logic [31:0] a);
      return rmem.exists(a) ? rmem[a] : pat(a);
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      bmem[a] = v;
      rmem[a] = v;
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input logic s);
      int n = 1 << w;
      logic [31:0] v = 0;
      logic [31:0] ba, wv;
      for (int i = 0; i < n; i++) begin
         ba = a + i;
         wv = rmem_rd({ba[31:2], 2'b00});
         v[8*i +: 8] = 8'(wv >> (8 * ba[1:0]));
      end
      if (!s && v[8*n-1])
         for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] wd);
      logic [31:0] ba, wa, wv;
      for (int i = 0; i < (1 << w); i++) begin
         ba = a + i;
         wa = {ba[31:2], 2'b00};
         wv = rmem_rd(wa);
         wv[8 * ba[1:0] +: 8] = wd[8*i +: 8];
         rmem[wa] = wv;
      end
   endtask

   function automatic logic exp_err(input logic [31:0] a, input logic [1:0] w);
      logic ill = (w == 2'b11);
      logic mis = (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
      return ill || (mis && 1'b0);
`else
      return ill || mis;
`endif
   endfunction

   function automatic int exp_beats(input logic [31:0] a, input logic [1:0] w);
      if (exp_err(a, w)) return 0;
      return (int'(a[1:0]) + (1 << w) > 4) ? 2 : 1;
   endfunction

   // Bus responder: decides ready at each falling edge, applies writes per strobe.
   typedef struct {
      logic [31:0] a;
      logic        we;
      logic [3:0]  st;
      logic [31:0] wd;
   } beat_t;

   beat_t beats[$];
   int    vcyc = 0;
   int    stab_err = 0;
   int    resp_dly = 0;
   bit    resp_rand = 0;
   bit    resp_stuck = 0;

   initial begin
      int    wcnt = 0;
      int    cur_dly = 0;
      bit    pw = 0;
      logic [68:0] pv = '0;
      logic [31:0] wv;
      bus_ready = 1'b0;
      bus_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus_valid) begin
            vcyc++;
            if (pw && pv !== {bus_addr, bus_we, bus_wstrb, bus_wdata}) stab_err++;
            if (!resp_stuck && wcnt >= cur_dly) begin
               bus_ready = 1'b1;
               bus_rdata = bmem_rd(bus_addr);
               if (bus_we) begin
                  wv = bmem_rd(bus_addr);
                  for (int k = 0; k < 4; k++)
                     if (bus_wstrb[k]) wv[8*k +: 8] = bus_wdata[8*k +: 8];
                  bmem[bus_addr] = wv;
               end
               beats.push_back('{a: bus_addr, we: bus_we, st: bus_wstrb, wd: bus_wdata});
               wcnt = 0;
               cur_dly = resp_rand ? int'($urandom_range(0, 3)) : resp_dly;
               pw = 0;
            end else begin
               bus_ready = 1'b0;
               bus_rdata = $urandom;
               wcnt++;
               pw = 1;
               pv = {bus_addr, bus_we, bus_wstrb, bus_wdata};
            end
         end else begin
            bus_ready = 1'b0;
            pw = 0;
            wcnt = 0;
            cur_dly = resp_rand ? int'($urandom_range(0, 3)) : resp_dly;
         end
      end
   end

   // One access from the core's side; cycle 1 is the IDLE cycle carrying req_valid.
   task automatic access(input logic rw, input logic [1:0] w, input logic s,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e,
                         output int cyc, output int stc, output bit to);
      beats.delete();
      vcyc = 0;
      to = 0;
      @(negedge clk);
      req_valid = 1'b1; memrw = rw; memword = w; memsign = s; addr = a; wdata = wd;
      #1;
      cyc = 1;
      stc = int'(stall);
      while (!done) begin
         @(negedge clk);
         req_valid = 1'b0;
         addr = $urandom; wdata = $urandom; memword = 2'($urandom); memsign = 1'($urandom);
         memrw = 1'($urandom);
         #1;
         cyc++;
         stc += int'(stall);
         if (cyc > 60) begin
            to = 1;
            break;
         end
      end
      rd = rdata;
      e  = err;
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; memrw = 1'b0; memword = 2'b00; memsign = 1'b0;
      addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid got %b exp 0", bus_valid); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      checks++; if (rdata !== 32'h0)    begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
      checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
      rst = 1'b0;
   endtask

   task automatic test_aligned_lw;
      logic [31:0] rd; logic e; int cyc, stc; bit to;
      set_word(32'h100, 32'hDEADBEEF);
      resp_rand = 0; resp_dly = 0;
      access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, e, cyc, stc, to);
      checks++; if (to) begin errors++; $display("FAIL lw_timeout got no done exp done"); end
      checks++; if (beats.size() != 1) begin errors++; $display("FAIL lw_beats got %0d exp 1", beats.size()); end
      else begin
         checks++; if (beats[0].a !== 32'h100 || beats[0].st !== 4'hF || beats[0].we !== 1'b0) begin
            errors++; $display("FAIL lw_bus got a=%h st=%b we=%b exp a=100 st=1111 we=0", beats[0].a, beats[0].st, beats[0].we);
         end
      end
      checks++; if (cyc != 3)              begin errors++; $display("FAIL lw_latency got %0d exp 3", cyc); end
      checks++; if (stc != 2)              begin errors++; $display("FAIL lw_stall_cycles got %0d exp 2", stc); end
      checks++; if (rd !== 32'hDEADBEEF)   begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
      checks++; if (e !== 1'b0)            begin errors++; $display("FAIL lw_err got %b exp 0", e); end
   endtask

   task automatic test_lb;
      logic [31:0] rd; logic e; int cyc, stc; bit to;
      set_word(32'h100, 32'h80112233);
      access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, e, cyc, stc, to);
      checks++; if (to || rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got %h exp ffffff80", rd); end
      checks++; if (beats.size() != 1 || beats[0].a !== 32'h100) begin errors++; $display("FAIL lb_addr got %0d beats exp 1 beat at 100", beats.size()); end
      access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, e, cyc, stc, to);
      checks++; if (to || rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got %h exp 00000080", rd); end
   endtask

   task automatic test_sh_delayed;
      logic [31:0] rd; logic e; int cyc, stc; bit to;
      set_word(32'h200, 32'h11111111);
      resp_dly = 3;
      stab_err = 0;
      access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, rd, e, cyc, stc, to);
      ref_store(32'h202, 2'b01, 32'h0000ABCD);
      resp_dly = 0;
      checks++; if (beats.size() != 1) begin errors++; $display("FAIL sh_beats got %0d exp 1", beats.size()); end
      else begin
         checks++; if (beats[0].st !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b exp 1100", beats[0].st); end
         checks++; if (beats[0].wd !== 32'hABCD0000 || beats[0].we !== 1'b1) begin
            errors++; $display("FAIL sh_wdata got %h we=%b exp abcd0000 we=1", beats[0].wd, beats[0].we);
         end
      end
      checks++; if (vcyc != 4)       begin errors++; $display("FAIL sh_valid_cycles got %0d exp 4", vcyc); end
      checks++; if (stab_err != 0)   begin errors++; $display("FAIL sh_stable got %0d changes exp 0", stab_err); end
      checks++; if (to || cyc != 6)  begin errors++; $display("FAIL sh_latency got %0d exp 6", cyc); end
      checks++; if (bmem_rd(32'h200) !== rmem_rd(32'h200)) begin
         errors++; $display("FAIL sh_mem got %h exp %h", bmem_rd(32'h200), rmem_rd(32'h200));
      end
   endtask

   task automatic test_misalign;
      logic [31:0] rd; logic e; int cyc, stc; bit to;
      set_word(32'h100, 32'h44332211);
      set_word(32'h104, 32'h88776655);
      access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, rd, e, cyc, stc, to);
      checks++; if (to) begin errors++; $display("FAIL mis_timeout got no done exp done"); end
`ifdef LSU_MISALIGN_SPLIT_EN
      checks++; if (beats.size() != 2) begin errors++; $display("FAIL mis_beats got %0d exp 2", beats.size()); end
      else begin
         checks++; if (beats[0].a !== 32'h100 || beats[1].a !== 32'h104) begin
            errors++; $display("FAIL mis_addr got %h,%h exp 100,104", beats[0].a, beats[1].a);
         end
      end
      checks++; if (rd !== 32'h55443322) begin errors++; $display("FAIL mis_rdata got %h exp 55443322", rd); end
      checks++; if (e !== 1'b0)          begin errors++; $display("FAIL mis_err got %b exp 0", e); end
`else
      checks++; if (e !== 1'b1)  begin errors++; $display("FAIL mis_err got %b exp 1", e); end
      checks++; if (vcyc != 0)   begin errors++; $display("FAIL mis_no_bus got %0d valid cycles exp 0", vcyc); end
`endif
   endtask

   task automatic test_illegal;
      logic [31:0] rd; logic e; int cyc, stc; bit to;
      access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, e, cyc, stc, to);
      checks++; if (to || e !== 1'b1 || cyc != 2) begin errors++; $display("FAIL ill_load got err=%b cyc=%0d exp err=1 cyc=2", e, cyc); end
      checks++; if (vcyc != 0) begin errors++; $display("FAIL ill_no_bus got %0d exp 0", vcyc); end
      access(1'b1, 2'b11, 1'b0, 32'h103, 32'h12345678, rd, e, cyc, stc, to);
      checks++; if (to || e !== 1'b1 || vcyc != 0) begin errors++; $display("FAIL ill_store got err=%b vcyc=%0d exp err=1 vcyc=0", e, vcyc); end
   endtask

   task automatic test_timeout;
      logic [31:0] rd; logic e; int cyc, stc; bit to;
      resp_stuck = 1;
      access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, rd, e, cyc, stc, to);
      resp_stuck = 0;
      checks++; if (to || e !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", e); end
      checks++; if (vcyc != 8)        begin errors++; $display("FAIL tmo_valid_cycles got %0d exp 8", vcyc); end
      checks++; if (rd !== 32'h0)     begin errors++; $display("FAIL tmo_rdata got %h exp 0", rd); end
      checks++; if (cyc != 10)        begin errors++; $display("FAIL tmo_latency got %0d exp 10", cyc); end
   endtask

   task automatic test_reset_midbeat;
      logic [31:0] rd; logic e; int cyc, stc; bit to;
      resp_stuck = 1;
      @(negedge clk);
      req_valid = 1'b1; memrw = 1'b1; memword = 2'b10; memsign = 1'b0;
      addr = 32'h500; wdata = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rstmid_in_beat got %b exp 1", bus_valid); end
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (bus_valid !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL rstmid_idle got valid=%b done=%b stall=%b exp 0 0 0", bus_valid, done, stall);
      end
      rst = 1'b0;
      resp_stuck = 0;
      access(1'b1, 2'b10, 1'b0, 32'h504, 32'h13579BDF, rd, e, cyc, stc, to);
      ref_store(32'h504, 2'b10, 32'h13579BDF);
      checks++; if (to || e !== 1'b0 || cyc != 3) begin errors++; $display("FAIL rstmid_sw got err=%b cyc=%0d exp err=0 cyc=3", e, cyc); end
      checks++; if (bmem_rd(32'h504) !== rmem_rd(32'h504)) begin
         errors++; $display("FAIL rstmid_mem got %h exp %h", bmem_rd(32'h504), rmem_rd(32'h504));
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, a, wd, el; logic e, rw, s, ee; logic [1:0] w;
      int cyc, stc, eb, bad_we; bit to;
      resp_rand = 1;
      stab_err = 0;
      for (int n = 0; n < 300; n++) begin
         rw = 1'($urandom);
         w  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         s  = 1'($urandom);
         a  = 32'h400 + $urandom_range(0, 63);
         wd = $urandom;
         ee = exp_err(a, w);
         eb = exp_beats(a, w);
         el = ref_load(a, w, s);
         access(rw, w, s, a, wd, rd, e, cyc, stc, to);
         if (rw && !ee) ref_store(a, w, wd);
         checks++; if (to || e !== ee) begin errors++; $display("FAIL rnd_err #%0d a=%h w=%0d got %b exp %b", n, a, w, e, ee); end
         checks++; if (beats.size() != eb) begin errors++; $display("FAIL rnd_beats #%0d a=%h w=%0d got %0d exp %0d", n, a, w, beats.size(), eb); end
         bad_we = 0;
         foreach (beats[i]) if (beats[i].we !== rw || beats[i].a !== {a[31:2], 2'b00} + 32'(4 * i)) bad_we++;
         checks++; if (bad_we != 0) begin errors++; $display("FAIL rnd_bus #%0d got %0d bad beats exp 0", n, bad_we); end
         if (!rw && !ee) begin
            checks++; if (rd !== el) begin errors++; $display("FAIL rnd_load #%0d a=%h w=%0d s=%b got %h exp %h", n, a, w, s, rd, el); end
         end
      end
      resp_rand = 0;
      for (int i = 0; i < 17; i++) begin
         a = 32'h400 + 32'(4 * i);
         checks++; if (bmem_rd(a) !== rmem_rd(a)) begin errors++; $display("FAIL rnd_mem a=%h got %h exp %h", a, bmem_rd(a), rmem_rd(a)); end
      end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL rnd_stable got %0d changes exp 0", stab_err); end
   endtask

   initial begin
      test_reset();
      test_aligned_lw();
      test_lb();
      test_sh_delayed();
      test_misalign();
      test_illegal();
      test_timeout();
      test_reset_midbeat();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
